weight_buffer_loader: RTL and testbench

Streaming loader and ping-pong controller for the weight line buffers. It takes a valid/ready stream of bank-wide weight words and scatters them over NUMBER_OF_WEIGHT_LINE_BUFFERS line buffers, with per-bank write enables. Each line buffer is split into two halves: the compute engine reads one half while the loader fills the other, and a swap handshake exchanges them. It sits between the DMA/weight stream and the write and read ports of the weight line buffers.

---
 rtl/weight_buffer_loader.sv | 167 ++++++++++++++++
 tb/tb_weight_buffer_loader.sv | 296 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/weight_buffer_loader.sv
// Weight line buffer loader: scatters a bank-word stream over N ping-pong line buffers.
// Optional protocol error flag built when WEIGHT_BUFFER_LOADER_ERR_EN is defined.
module weight_buffer_loader #(
    parameter int WEIGHT_BANK_BIT_WIDTH         = 64,
    parameter int WEIGHT_BUFFER_BANK_COUNT      = 8,
    parameter int WEIGHT_LINE_BUFFER_DEPTH      = 512,
    parameter int NUMBER_OF_WEIGHT_LINE_BUFFERS = 6,
    localparam int W     = WEIGHT_BANK_BIT_WIDTH,
    localparam int BANKS = WEIGHT_BUFFER_BANK_COUNT,
    localparam int N     = NUMBER_OF_WEIGHT_LINE_BUFFERS,
    localparam int AW    = $clog2(WEIGHT_LINE_BUFFER_DEPTH),
    localparam int HW    = $clog2(WEIGHT_LINE_BUFFER_DEPTH / 2)
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             load_start,
    input  logic [HW:0]      load_line_count,
    input  logic [W-1:0]     s_data,
    input  logic             s_valid,
    output logic             s_ready,
    output logic [N-1:0]     write_port_enable,
    output logic [W-1:0]     write_port_data_in [N],
    output logic [BANKS-1:0] write_port_wen [N],
    output logic [AW-1:0]    write_port_addr [N],
    input  logic [HW-1:0]    rd_line,
    output logic [AW-1:0]    read_port_addr [N],
    input  logic             swap_req,
    output logic             swap_ack,
    output logic             load_done,
    output logic             read_valid,
    output logic             err
);

    localparam int BW = (BANKS > 1) ? $clog2(BANKS) : 1;
    localparam int NW = (N > 1) ? $clog2(N) : 1;
    localparam logic [HW:0]    HALF      = (HW + 1)'(WEIGHT_LINE_BUFFER_DEPTH / 2);
    localparam logic [BW-1:0]  LAST_BANK = BW'(BANKS - 1);
    localparam logic [NW-1:0]  LAST_BUF  = NW'(N - 1);

    localparam logic [1:0] IDLE = 2'd0;
    localparam logic [1:0] LOAD = 2'd1;
    localparam logic [1:0] FULL = 2'd2;

    logic [1:0]    state;
    logic          read_half;
    logic          fill_half;
    logic [HW-1:0] line_last;
    logic [BW-1:0] bank_cnt;
    logic [NW-1:0] buf_cnt;
    logic [HW-1:0] line_cnt;
    logic [HW:0]   count_clamped;
    logic          start_ok;
    logic          handshake;
    logic          last_word;

    assign fill_half = ~read_half;
    // A start landing in the swap_ack cycle is dropped, even though state is already IDLE.
    assign start_ok  = (state == IDLE) && load_start && !swap_ack;
    assign handshake = (state == LOAD) && s_valid && s_ready;
    assign last_word = (bank_cnt == LAST_BANK) && (buf_cnt == LAST_BUF)
                    && (line_cnt == line_last);

    always_comb begin
        count_clamped = load_line_count;
        if (load_line_count == '0)
            count_clamped = (HW + 1)'(1);
        else if (load_line_count > HALF)
            count_clamped = HALF;
    end

    always_comb begin
        for (int i = 0; i < N; i++)
            read_port_addr[i] = AW'({read_half, rd_line});
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state      <= IDLE;
            read_half  <= 1'b0;
            read_valid <= 1'b0;
            s_ready    <= 1'b0;
            swap_ack   <= 1'b0;
            load_done  <= 1'b0;
            line_last  <= '0;
            bank_cnt   <= '0;
            buf_cnt    <= '0;
            line_cnt   <= '0;
            write_port_enable <= '0;
            for (int i = 0; i < N; i++) begin
                write_port_wen[i]     <= '0;
                write_port_addr[i]    <= '0;
                write_port_data_in[i] <= '0;
            end
        end else begin
            swap_ack  <= 1'b0;
            load_done <= 1'b0;
            for (int i = 0; i < N; i++) begin
                write_port_enable[i] <= 1'b0;
                write_port_wen[i]    <= '0;
                if (handshake && buf_cnt == NW'(i)) begin
                    write_port_enable[i]  <= 1'b1;
                    write_port_wen[i]     <= BANKS'(1) << bank_cnt;
                    write_port_addr[i]    <= AW'({fill_half, line_cnt});
                    write_port_data_in[i] <= s_data;
                end
            end
            unique case (state)
                IDLE: begin
                    if (start_ok) begin
                        line_last <= HW'(count_clamped - (HW + 1)'(1));
                        bank_cnt  <= '0;
                        buf_cnt   <= '0;
                        line_cnt  <= '0;
                        s_ready   <= 1'b1;
                        state     <= LOAD;
                    end
                end
                LOAD: begin
                    if (handshake) begin
                        if (bank_cnt == LAST_BANK) begin
                            bank_cnt <= '0;
                            if (buf_cnt == LAST_BUF) begin
                                buf_cnt  <= '0;
                                line_cnt <= line_cnt + HW'(1);
                            end else begin
                                buf_cnt <= buf_cnt + NW'(1);
                            end
                        end else begin
                            bank_cnt <= bank_cnt + BW'(1);
                        end
                        if (last_word) begin
                            s_ready   <= 1'b0;
                            load_done <= 1'b1;
                            state     <= FULL;
                        end
                    end
                end
                FULL: begin
                    if (swap_req) begin
                        read_half  <= ~read_half;
                        read_valid <= 1'b1;
                        swap_ack   <= 1'b1;
                        state      <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

`ifdef WEIGHT_BUFFER_LOADER_ERR_EN
    logic count_bad;
    assign count_bad = (load_line_count == '0) || (load_line_count > HALF);

    always_ff @(posedge clk or posedge reset) begin
        if (reset)
            err <= 1'b0;
        else if ((load_start && state != IDLE)
              || (swap_req && state == LOAD)
              || (start_ok && count_bad))
            err <= 1'b1;
    end
`else
    assign err = 1'b0;
`endif

endmodule

// File: tb/tb_weight_buffer_loader.sv
// Bench for weight_buffer_loader: directed table, corner sequences and a
// randomized run against a queue-based reference model.
module tb_weight_buffer_loader;

    localparam int W    = 16;
    localparam int B    = 2;
    localparam int N    = 2;
    localparam int D    = 8;
    localparam int HALF = 4;
    localparam int AW   = 3;
    localparam int HW   = 2;

`ifdef WEIGHT_BUFFER_LOADER_ERR_EN
    localparam bit ERR_EN = 1'b1;
`else
    localparam bit ERR_EN = 1'b0;
`endif

    logic          clk = 1'b0;
    logic          reset = 1'b0;
    logic          load_start = 1'b0;
    logic [HW:0]   load_line_count = '0;
    logic [W-1:0]  s_data = '0;
    logic          s_valid = 1'b0;
    logic          s_ready;
    logic [N-1:0]  write_port_enable;
    logic [W-1:0]  write_port_data_in [N];
    logic [B-1:0]  write_port_wen [N];
    logic [AW-1:0] write_port_addr [N];
    logic [HW-1:0] rd_line = '0;
    logic [AW-1:0] read_port_addr [N];
    logic          swap_req = 1'b0;
    logic          swap_ack;
    logic          load_done;
    logic          read_valid;
    logic          err;

    weight_buffer_loader #(
        .WEIGHT_BANK_BIT_WIDTH(W),
        .WEIGHT_BUFFER_BANK_COUNT(B),
        .WEIGHT_LINE_BUFFER_DEPTH(D),
        .NUMBER_OF_WEIGHT_LINE_BUFFERS(N)
    ) dut (
        .clk(clk),
        .reset(reset),
        .load_start(load_start),
        .load_line_count(load_line_count),
        .s_data(s_data),
        .s_valid(s_valid),
        .s_ready(s_ready),
        .write_port_enable(write_port_enable),
        .write_port_data_in(write_port_data_in),
        .write_port_wen(write_port_wen),
        .write_port_addr(write_port_addr),
        .rd_line(rd_line),
        .read_port_addr(read_port_addr),
        .swap_req(swap_req),
        .swap_ack(swap_ack),
        .load_done(load_done),
        .read_valid(read_valid),
        .err(err)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int failures = 0;
    int writes_seen = 0;

    task automatic chk(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Reference model: a load is a queue of (buffer, bank, line) slots
    int plan_buf[$];
    int plan_bank[$];
    int plan_line[$];
    bit m_loading, m_full, m_rh, m_rv, m_err, m_ack;
    bit e_done, e_ack;
    logic [N-1:0] e_en;
    logic [B-1:0] e_wen;
    int e_addr;
    int e_data;

    function automatic void model_reset();
        plan_buf.delete();
        plan_bank.delete();
        plan_line.delete();
        m_loading = 0; m_full = 0; m_rh = 0; m_rv = 0; m_err = 0; m_ack = 0;
        e_done = 0; e_ack = 0; e_en = '0; e_wen = '0; e_addr = 0; e_data = 0;
    endfunction

    function automatic void model_step(bit ls, int cnt, bit sv, int sd, bit sw);
        int b, k, l, c;
        e_en = '0; e_wen = '0; e_done = 0; e_ack = 0;
        if (m_loading) begin
            if (ls || sw) m_err = 1;
            if (sv) begin
                b = plan_buf.pop_front();
                k = plan_bank.pop_front();
                l = plan_line.pop_front();
                e_en   = N'(1 << b);
                e_wen  = B'(1 << k);
                e_addr = (m_rh ? 0 : HALF) + l;
                e_data = sd & 16'hFFFF;
                if (plan_buf.size() == 0) begin
                    m_loading = 0; m_full = 1; e_done = 1;
                end
            end
        end else if (m_full) begin
            if (ls) m_err = 1;
            if (sw) begin
                m_rh = !m_rh; m_rv = 1; e_ack = 1; m_full = 0;
            end
        end else if (ls && !m_ack) begin
            c = cnt;
            if (c == 0) begin c = 1; m_err = 1; end
            else if (c > HALF) begin c = HALF; m_err = 1; end
            for (int ln = 0; ln < c; ln++)
                for (int bf = 0; bf < N; bf++)
                    for (int bk = 0; bk < B; bk++) begin
                        plan_buf.push_back(bf);
                        plan_bank.push_back(bk);
                        plan_line.push_back(ln);
                    end
            m_loading = 1;
        end
        m_ack = e_ack;
    endfunction

    task automatic step(input bit ls, input int cnt, input bit sv, input int sd,
                        input bit sw, input int rl);
        load_start = ls; load_line_count = 3'(cnt);
        s_valid = sv; s_data = 16'(sd);
        swap_req = sw; rd_line = 2'(rl);
        model_step(ls, cnt, sv, sd, sw);
        @(posedge clk); #1;
        chk("s_ready", s_ready, m_loading);
        chk("enable", write_port_enable, e_en);
        for (int i = 0; i < N; i++) begin
            chk("wen", write_port_wen[i], e_en[i] ? e_wen : '0);
            if (e_en[i]) begin
                chk("addr", write_port_addr[i], e_addr);
                chk("data", write_port_data_in[i], e_data);
            end
            chk("rd_addr", read_port_addr[i], {m_rh, 2'(rl)});
        end
        chk("load_done", load_done, e_done);
        chk("swap_ack", swap_ack, e_ack);
        chk("read_valid", read_valid, m_rv);
        chk("err", err, m_err & ERR_EN);
        if (write_port_enable != '0) writes_seen++;
    endtask

    task automatic check_zero(input string tag);
        chk({tag, "_s_ready"}, s_ready, 0);
        chk({tag, "_enable"}, write_port_enable, 0);
        for (int i = 0; i < N; i++) begin
            chk({tag, "_wen"}, write_port_wen[i], 0);
            chk({tag, "_addr"}, write_port_addr[i], 0);
            chk({tag, "_data"}, write_port_data_in[i], 0);
            chk({tag, "_rd_addr"}, read_port_addr[i], {1'b0, rd_line});
        end
        chk({tag, "_load_done"}, load_done, 0);
        chk({tag, "_swap_ack"}, swap_ack, 0);
        chk({tag, "_read_valid"}, read_valid, 0);
        chk({tag, "_err"}, err, 0);
    endtask

    task automatic do_reset();
        load_start = 0; s_valid = 0; swap_req = 0; s_data = '0;
        reset = 1'b1;
        @(posedge clk); #1;
        check_zero("reset");
        reset = 1'b0;
        model_reset();
    endtask

    typedef struct {
        bit ls; logic [2:0] cnt; bit sv; logic [15:0] sd; bit sw; logic [1:0] rl;
        bit rdy; logic [1:0] en; logic [1:0] w0; logic [1:0] w1;
        logic [2:0] addr; logic [15:0] data; bit done; bit ack; bit rv;
        logic [2:0] rda;
    } row_t;

    function automatic row_t mk(bit ls, int cnt, bit sv, int sd, bit sw, int rl,
                                bit rdy, int en, int w0, int w1, int addr,
                                int data, bit done, bit ack, bit rv, int rda);
        row_t r;
        r.ls = ls; r.cnt = 3'(cnt); r.sv = sv; r.sd = 16'(sd); r.sw = sw;
        r.rl = 2'(rl); r.rdy = rdy; r.en = 2'(en); r.w0 = 2'(w0); r.w1 = 2'(w1);
        r.addr = 3'(addr); r.data = 16'(data); r.done = done; r.ack = ack;
        r.rv = rv; r.rda = 3'(rda);
        return r;
    endfunction

    row_t rows [18];
    int idx;
    int bf, bk, ln;

    initial begin
        rows[0]  = mk(1, 1, 0, 0,       0, 0, 1, 0, 0, 0, 0, 0,       0, 0, 0, 0);
        rows[1]  = mk(0, 0, 1, 'hA0A0, 0, 0, 1, 1, 1, 0, 4, 'hA0A0, 0, 0, 0, 0);
        rows[2]  = mk(0, 0, 1, 'hB1B1, 0, 0, 1, 1, 2, 0, 4, 'hB1B1, 0, 0, 0, 0);
        rows[3]  = mk(0, 0, 1, 'hC2C2, 0, 0, 1, 2, 0, 1, 4, 'hC2C2, 0, 0, 0, 0);
        rows[4]  = mk(0, 0, 1, 'hD3D3, 0, 0, 0, 2, 0, 2, 4, 'hD3D3, 1, 0, 0, 0);
        rows[5]  = mk(0, 0, 1, 'h1111, 1, 0, 0, 0, 0, 0, 0, 0,       0, 1, 1, 4);
        rows[6]  = mk(1, 2, 1, 'h2222, 0, 0, 0, 0, 0, 0, 0, 0,       0, 0, 1, 4);
        rows[7]  = mk(1, 2, 0, 0,       0, 3, 1, 0, 0, 0, 0, 0,       0, 0, 1, 7);
        for (int k = 0; k < 8; k++) begin
            bf = (k / 2) % 2; bk = k % 2; ln = k / 4;
            rows[8 + k] = mk(0, 0, 1, 'hE000 + k, 0, 3, k != 7, 1 << bf,
                             bf == 0 ? (1 << bk) : 0, bf == 1 ? (1 << bk) : 0,
                             ln, 'hE000 + k, k == 7, 0, 1, 7);
        end
        rows[16] = mk(0, 0, 1, 'h3333, 1, 3, 0, 0, 0, 0, 0, 0,       0, 1, 1, 3);
        rows[17] = mk(0, 0, 0, 0,       0, 3, 0, 0, 0, 0, 0, 0,       0, 0, 1, 3);

        #1;
        do_reset();

        foreach (rows[r]) begin
            load_start = rows[r].ls; load_line_count = rows[r].cnt;
            s_valid = rows[r].sv; s_data = rows[r].sd;
            swap_req = rows[r].sw; rd_line = rows[r].rl;
            @(posedge clk); #1;
            chk("t_s_ready", s_ready, rows[r].rdy);
            chk("t_enable", write_port_enable, rows[r].en);
            chk("t_wen0", write_port_wen[0], rows[r].w0);
            chk("t_wen1", write_port_wen[1], rows[r].w1);
            if (rows[r].en != 0) begin
                idx = rows[r].en[1] ? 1 : 0;
                chk("t_addr", write_port_addr[idx], rows[r].addr);
                chk("t_data", write_port_data_in[idx], rows[r].data);
            end
            chk("t_load_done", load_done, rows[r].done);
            chk("t_swap_ack", swap_ack, rows[r].ack);
            chk("t_read_valid", read_valid, rows[r].rv);
            chk("t_rd_addr0", read_port_addr[0], rows[r].rda);
            chk("t_rd_addr1", read_port_addr[1], rows[r].rda);
            chk("t_err", err, 0);
        end

        // s_valid toggling on a count=4 load
        do_reset();
        writes_seen = 0;
        step(1, 4, 0, 0, 0, 1);
        for (int i = 0; i < 32; i++)
            step(0, 0, (i % 2) == 0, 'h5000 + i, 0, 1);
        chk("toggle_write_count", writes_seen, 16);
        step(0, 0, 0, 0, 1, 1);
        step(0, 0, 0, 0, 0, 1);

        // reset in the middle of a load, with read_half currently 1
        step(1, 4, 0, 0, 0, 2);
        for (int i = 0; i < 3; i++)
            step(0, 0, 1, 'h7000 + i, 0, 2);
        s_valid = 1'b1; s_data = 16'h7777; rd_line = 2'd2;
        reset = 1'b1;
        @(posedge clk); #1;
        check_zero("midload");
        reset = 1'b0;
        model_reset();
        for (int i = 0; i < 4; i++)
            step(0, 0, 1, 'h7100 + i, 0, 2);

        // load_start during LOAD: flagged in the error build, load unaffected
        do_reset();
        step(1, 1, 0, 0, 0, 0);
        step(0, 0, 1, 'h9000, 0, 0);
        step(1, 2, 1, 'h9001, 0, 0);
        step(0, 0, 1, 'h9002, 0, 0);
        step(0, 0, 1, 'h9003, 1, 0);
        step(0, 0, 0, 0, 0, 0);
        step(0, 0, 0, 0, 1, 0);
        for (int i = 0; i < 3; i++)
            step(0, 0, 0, 0, 0, 0);
        chk("err_sticky", err, ERR_EN);

        // randomized run, illegal counts included
        do_reset();
        for (int i = 0; i < 800; i++)
            step($urandom_range(0, 9) == 0, $urandom_range(0, 7),
                 $urandom_range(0, 3) != 0, int'($urandom & 16'hFFFF),
                 $urandom_range(0, 3) == 0, $urandom_range(0, 3));

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
